// File: rtl/fetch_unit_sc.sv
// fetch_unit_sc: instruction fetch stage for the single-cycle controller.
// Owns the PC and fetches one instruction at a time over a req/ready,
// rvalid/rdata memory handshake. It holds the fetched word and splits it
// into decode fields. exec_en marks the one cycle in which downstream
// writes are allowed.
// Optional feature: define FETCH_RETIRE_CNT_EN to add the retired_cnt port
// and its 32-bit retired-instruction counter.
module fetch_unit_sc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] Result,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        exec_en,
    output logic [31:0] Instr,
    output logic [3:0]  Cond,
    output logic [1:0]  Op,
    output logic [5:0]  Funct,
    output logic [3:0]  Rn,
    output logic [3:0]  Rd,
    output logic [3:0]  Rm,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8
`ifdef FETCH_RETIRE_CNT_EN
    ,
    output logic [31:0] retired_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_EXEC = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic        idle_armed_reg;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;

    // Branch targets are forced word-aligned, so Result[1:0] is never used.
    logic        result_lsb_unused;
    assign result_lsb_unused = ^Result[1:0];

    // State, PC and instruction registers; reset clears them asynchronously.
    // idle_armed_reg makes IDLE last one full clock period after reset
    // release: the first edge arms it and the second edge moves to REQ.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            idle_armed_reg <= 1'b0;
            pc_reg         <= {RESET_PC[31:2], 2'b00};
            instr_reg      <= 32'h0000_0000;
        end else begin
            state_reg      <= state_next;
            idle_armed_reg <= 1'b1;
            pc_reg         <= pc_next;
            instr_reg      <= instr_next;
        end
    end

    // Next-state logic. The PC advances only when leaving EXEC, and Instr
    // loads only on the WAIT->EXEC transition.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        case (state_reg)
            S_IDLE: begin
                if (idle_armed_reg) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    instr_next = imem_rdata;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_next    = PCSrc ? {Result[31:2], 2'b00} : pc_reg + 32'd4;
                state_next = S_REQ;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign imem_req  = (state_reg == S_REQ);
    assign imem_addr = pc_reg;
    assign exec_en   = (state_reg == S_EXEC);

    assign Instr   = instr_reg;
    assign Cond    = instr_reg[31:28];
    assign Op      = instr_reg[27:26];
    assign Funct   = instr_reg[25:20];
    assign Rn      = instr_reg[19:16];
    assign Rd      = instr_reg[15:12];
    assign Rm      = instr_reg[3:0];
    assign PC      = pc_reg;
    assign PCPlus8 = pc_reg + 32'd8;

`ifdef FETCH_RETIRE_CNT_EN
    logic [31:0] retired_cnt_reg;

    // Count completed EXEC cycles; wraps naturally at 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired_cnt_reg <= 32'h0000_0000;
        end else if (state_reg == S_EXEC) begin
            retired_cnt_reg <= retired_cnt_reg + 32'd1;
        end
    end

    assign retired_cnt = retired_cnt_reg;
`endif

endmodule
